branch_pred_ctrl: RTL

- Dynamic branch predictor and redirect controller for the 6-stage core.
- Fetch side: looks up a direct-mapped BTB with 2-bit saturating counters and supplies a predicted-taken flag and target for the fetch PC mux.
- Execute side: receives the resolved outcome (branch-condition result, jump, jalr), updates the table, and on a misprediction issues a registered one-cycle flush with the corrected PC.
- Keeps performance counters for resolved control-flow instructions and mispredictions.

---
 rtl/branch_pred_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/branch_pred_ctrl.sv
// Purpose: direct-mapped BTB with 2-bit counters; predicts at fetch, trains and redirects at execute.
// Latency: lookup is combinational; table/counters update and flush/redirect_pc appear one edge after resolve.
// Backpressure: none; resolves arriving while flush=1 are wrong-path and dropped.
module branch_pred_ctrl #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] f_pc,
  output logic        p_taken,
  output logic [31:0] p_target,
  input  logic        e_valid,
  input  logic [31:0] e_pc,
  input  logic        e_is_branch,
  input  logic        e_is_jal,
  input  logic        e_is_jalr,
  input  logic        e_taken,
  input  logic [31:0] e_target,
  input  logic        e_pred_taken,
  input  logic [31:0] e_pred_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int N     = 2 ** IDX_W;
  localparam int TAG_L = IDX_W + 2;
  localparam int TAG_H = IDX_W + TAG_W + 1;

  // Table storage: one entry per index.
  logic             valid_q  [N];
  logic [TAG_W-1:0] tag_q    [N];
  logic [31:0]      target_q [N];
  logic [1:0]       ctr_q    [N];
  logic             jmp_q    [N];

  // Fetch-side lookup signals
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  // Execute-side resolve signals
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             e_hit;
  logic             accepted;
  logic             mispredict;
  logic [31:0]      fix_pc;

  // Pending table write, computed combinationally and committed on the edge
  logic             upd_en;
  logic [TAG_W-1:0] upd_tag;
  logic [31:0]      upd_target;
  logic [1:0]       upd_ctr;
  logic             upd_jmp;

  // PC bits outside the index/tag fields carry no information for the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[31:TAG_H+1], f_pc[1:0]};

  // Fetch lookup reads registered state only, so a same-cycle update is not visible yet.
  always_comb begin
    f_idx    = f_pc[IDX_W+1:2];
    f_tag    = f_pc[TAG_H:TAG_L];
    f_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    p_taken  = f_hit && (jmp_q[f_idx] || ctr_q[f_idx][1]);
    p_target = p_taken ? target_q[f_idx] : 32'd0;
  end

  // Resolve qualification and misprediction detection.
  always_comb begin
    e_idx      = e_pc[IDX_W+1:2];
    e_tag      = e_pc[TAG_H:TAG_L];
    e_hit      = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    accepted   = e_valid && !flush;
    mispredict = accepted &&
                 ((e_taken != e_pred_taken) ||
                  (e_taken && e_pred_taken && (e_target != e_pred_target)));
    fix_pc     = e_taken ? e_target : (e_pc + 32'd4);
  end

  // Decide what, if anything, gets written into the entry at e_idx.
  always_comb begin
    upd_en     = 1'b0;
    upd_tag    = tag_q[e_idx];
    upd_target = target_q[e_idx];
    upd_ctr    = ctr_q[e_idx];
    upd_jmp    = jmp_q[e_idx];
    if (accepted && !e_is_jalr) begin
      if (e_is_jal) begin
        // Unconditional jumps always take over the slot and predict taken.
        upd_en     = 1'b1;
        upd_tag    = e_tag;
        upd_target = e_target;
        upd_ctr    = 2'b11;
        upd_jmp    = 1'b1;
      end else if (e_is_branch) begin
        if (e_hit) begin
          upd_en = 1'b1;
          if (e_taken) begin
            upd_ctr    = (ctr_q[e_idx] == 2'b11) ? 2'b11 : ctr_q[e_idx] + 2'b01;
            upd_target = e_target;
          end else begin
            upd_ctr    = (ctr_q[e_idx] == 2'b00) ? 2'b00 : ctr_q[e_idx] - 2'b01;
          end
        end else if (e_taken) begin
          // Allocate weakly taken; any aliased entry is evicted.
          upd_en     = 1'b1;
          upd_tag    = e_tag;
          upd_target = e_target;
          upd_ctr    = 2'b10;
          upd_jmp    = 1'b0;
        end
      end
    end
  end

  // Table state: cleared to invalid / weakly-not-taken on reset, one entry written per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
        jmp_q[i]    <= 1'b0;
      end
    end else if (upd_en) begin
      valid_q[e_idx]  <= 1'b1;
      tag_q[e_idx]    <= upd_tag;
      target_q[e_idx] <= upd_target;
      ctr_q[e_idx]    <= upd_ctr;
      jmp_q[e_idx]    <= upd_jmp;
    end
  end

  // Registered one-cycle flush; it can never repeat back to back since flush blocks acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush       <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      flush <= mispredict;
      if (mispredict) begin
        redirect_pc <= fix_pc;
      end
    end
  end

  // Performance counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_cnt      <= 32'd0;
      mispred_cnt <= 32'd0;
    end else begin
      if (accepted) begin
        br_cnt <= br_cnt + 32'd1;
      end
      if (mispredict) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end

endmodule
